// File: rtl/branch_sequencer.sv
// branch_sequencer: PC sequencer with req/ack fetch, taken-branch redirect/flush and halt at exit address
module branch_sequencer #(
  parameter int              PC_W         = 8,
  parameter int              PC_STEP      = 4,
  parameter logic [PC_W-1:0] RESET_PC     = 8'h04,
  parameter logic [PC_W-1:0] EXIT_PC      = 8'h80,
  parameter int              FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            br_valid,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic            fetch_ack,
  output logic            fetch_req,
  output logic [PC_W-1:0] pc,
  output logic            flush,
  output logic            halted,
  output logic [7:0]      br_count
);
  localparam int CW = FLUSH_CYCLES > 1 ? $clog2(FLUSH_CYCLES) : 1;
  typedef enum logic [1:0] {FETCH, FLUSH, HALT} state_e;
  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            flush_q, flush_d, halted_q, halted_d;
  logic [7:0]      bc_q, bc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            take;
  logic [7:0]      bc_inc;
  assign take      = br_valid && br_taken;
  assign bc_inc    = bc_q + {7'd0, bc_q != 8'hFF};
  assign fetch_req = (state_q == FETCH) && (pc_q != EXIT_PC);
  assign pc        = pc_q;
  assign flush     = flush_q;
  assign halted    = halted_q;
  assign br_count  = bc_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      flush_q  <= 1'b0;
      halted_q <= 1'b0;
      bc_q     <= 8'd0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      flush_q  <= flush_d;
      halted_q <= halted_d;
      bc_q     <= bc_d;
      cnt_q    <= cnt_d;
    end
  end
  // A taken branch outranks everything except HALT, in both FETCH and FLUSH
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    flush_d  = flush_q;
    halted_d = halted_q;
    bc_d     = bc_q;
    cnt_d    = cnt_q;
    if (state_q != HALT && take) begin
      state_d = FLUSH;
      pc_d    = br_target;
      flush_d = 1'b1;
      cnt_d   = CW'(FLUSH_CYCLES - 1);
      bc_d    = bc_inc;
    end else if (state_q == FETCH) begin
      if (pc_q == EXIT_PC) begin
        state_d  = HALT;
        halted_d = 1'b1;
      end else if (fetch_ack && !stall) pc_d = pc_q + PC_W'(PC_STEP);
    end else if (state_q == FLUSH) begin
      if (cnt_q == '0) begin
        state_d = FETCH;
        flush_d = 1'b0;
      end else cnt_d = cnt_q - 1'b1;
    end
  end
endmodule

// File: tb/tb_branch_sequencer.sv
// tb_branch_sequencer: directed + random stimulus against a cycle-level behavioural model
module tb_branch_sequencer;
  logic       clk = 0, rst = 0, stall = 0, br_valid = 0, br_taken = 0, fetch_ack = 0;
  logic [7:0] br_target = 0;
  logic       fetch_req, flush, halted;
  logic [7:0] pc, br_count;
  int n_checks = 0, n_fail = 0;
  int m_pc = 4, m_left = 0, m_cnt = 0;
  bit m_halt = 0;

  branch_sequencer dut (
    .clk(clk), .rst(rst), .stall(stall), .br_valid(br_valid), .br_taken(br_taken),
    .br_target(br_target), .fetch_ack(fetch_ack), .fetch_req(fetch_req), .pc(pc),
    .flush(flush), .halted(halted), .br_count(br_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    check("pc", {24'd0, pc}, m_pc);
    check("flush", {31'd0, flush}, {31'd0, m_left > 0});
    check("halted", {31'd0, halted}, {31'd0, m_halt});
    check("br_count", {24'd0, br_count}, m_cnt);
    check("fetch_req", {31'd0, fetch_req}, {31'd0, !m_halt && m_left == 0 && m_pc != 'h80});
  endtask

  // Model: flush lasts FLUSH_CYCLES after the latest taken branch; halt once pc sits at exit in fetch
  task automatic step(input bit r, input bit s, input bit bv, input bit bt, input logic [7:0] tg, input bit a);
    rst = r; stall = s; br_valid = bv; br_taken = bt; br_target = tg; fetch_ack = a;
    @(posedge clk);
    if (r) begin m_pc = 4; m_left = 0; m_halt = 0; m_cnt = 0; end
    else if (m_halt) ;
    else if (bv && bt) begin m_pc = tg; m_left = 2; m_cnt = m_cnt < 255 ? m_cnt + 1 : 255; end
    else if (m_left > 0) m_left--;
    else if (m_pc == 'h80) m_halt = 1;
    else if (a && !s) m_pc = (m_pc + 4) % 256;
    #1 check_all();
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < 64 && m_pc != target; i++) step(0, 0, 0, 0, 0, 1);
    check("reach_pc", {24'd0, pc}, target);
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 0);
    check("rst_pc", {24'd0, pc}, 32'h04);
    check("rst_req", {31'd0, fetch_req}, 1);
    for (int i = 0; i < 40 && !m_halt; i++) step(0, 0, 0, 0, 0, 1);
    check("t1_halted", {31'd0, halted}, 1);
    check("t1_pc", {24'd0, pc}, 32'h80);
    step(0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0);
    run_to('h38);
    step(0, 0, 1, 1, 8'h10, 0);
    check("t2_pc", {24'd0, pc}, 32'h10);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    check("t2_cnt", {24'd0, br_count}, 1);
    step(0, 0, 0, 0, 0, 1);
    check("t2_fetch", {24'd0, pc}, 32'h14);
    step(0, 0, 1, 0, 8'h60, 1);
    check("t3_pc", {24'd0, pc}, 32'h18);
    run_to('h20);
    repeat (3) step(0, 1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    check("t4_pc", {24'd0, pc}, 32'h24);
    step(0, 0, 1, 1, 8'h38, 1);
    step(0, 0, 1, 1, 8'h50, 1);
    check("t5_pc", {24'd0, pc}, 32'h50);
    repeat (3) step(0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 1, 8'hFC, 0);
    step(1, 0, 0, 0, 0, 0);
    check("t6_cnt", {24'd0, br_count}, 0);
    step(0, 0, 1, 1, 8'hFC, 0);
    repeat (3) step(0, 0, 0, 0, 0, 1);
    check("wrap_pc", {24'd0, pc}, 32'h00);
    step(0, 0, 1, 1, 8'h80, 0);
    repeat (4) step(0, 0, 0, 0, 0, 1);
    check("br_exit_halt", {31'd0, halted}, 1);
    step(0, 0, 1, 1, 8'h10, 1);
    check("halt_ignores_br", {24'd0, pc}, 32'h80);
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] t;
      int pb;
      t = ($urandom_range(0, 9) == 0) ? 8'h80 : 8'($urandom) & 8'hFC;
      pb = (i >= 1000 && i < 1400) ? 95 : 10;
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 99) < pb + 10, $urandom_range(0, 99) < pb * 8, t,
           $urandom_range(0, 3) != 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
